// File: rtl/ebus_master_seq.sv
// ebus_master_seq: EBOX-side EBUS transaction sequencer.
// Accepts one I/O request at a time and runs it through the
// cs/func/demand/ack/xfer handshake. The request drives write data onto the bus
// or captures read data. Every wait state has a timeout, and every request gets
// exactly one response pulse.
//
// Function codes: 000 CONO, 001 CONI, 010 DATAO, 011 DATAI,
//                 100 PIserved, 101 PIaddrIn, 110/111 illegal.
//
// Optional feature: define EBUS_PARITY_EN to enable the following parity behaviour:
//   - odd parity is generated on write data;
//   - odd parity is checked on read capture.
// Without the macro, ebusParityOut and rspParErr stay 0 and ebusParityIn is ignored.
module ebus_master_seq #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqFunc,
  input  logic [6:0]  reqCS,
  input  logic [35:0] reqData,
  output logic        rspValid,
  output logic [35:0] rspData,
  output logic        rspTimeout,
  output logic        rspParErr,
  output logic [6:0]  ebusCS,
  output logic [2:0]  ebusFunc,
  output logic        ebusDemand,
  output logic [36:0] ebusDrv,
  output logic        ebusParityOut,
  input  logic [35:0] ebusData,
  input  logic        ebusParityIn,
  input  logic        ebusAck,
  input  logic        ebusXfer
);

  localparam logic [2:0] F_CONO     = 3'b000;
  localparam logic [2:0] F_CONI     = 3'b001;
  localparam logic [2:0] F_DATAO    = 3'b010;
  localparam logic [2:0] F_DATAI    = 3'b011;
  localparam logic [2:0] F_PIADDRIN = 3'b101;

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_DEMAND  = 3'd2,
    S_XFER    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]    r_func;
  logic [6:0]    r_cs;
  logic [35:0]   r_wdata;
  logic [35:0]   r_rdata;
  logic          r_perr;
  logic          r_abort;
  logic [SW-1:0] r_setup_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_tmo;
  logic [35:0]   r_rsp_data;
  logic          r_rsp_perr;

  logic w_accept;
  logic w_illegal;
  logic w_illegal_acc;
  logic w_is_write;
  logic w_is_read;
  logic w_driving;
  logic w_tmo_hit;
  logic w_capture;
  logic w_abort;
  logic w_done;
  logic w_any_abort;
  logic w_par_bad;

  assign w_accept      = reqValid && (r_state == S_IDLE);
  assign w_illegal     = (reqFunc[2:1] == 2'b11);
  assign w_illegal_acc = w_accept && w_illegal;
  assign w_is_write    = (r_func == F_CONO) || (r_func == F_DATAO);
  assign w_is_read     = (r_func == F_CONI) || (r_func == F_DATAI) || (r_func == F_PIADDRIN);
  assign w_tmo_hit     = (r_tmo_cnt == TMO_LAST);
  assign w_any_abort   = r_abort || w_abort;

  // Write data is on the bus from setup until the master lets go in RELEASE.
  assign w_driving = w_is_write &&
                     ((r_state == S_SETUP) || (r_state == S_DEMAND) || (r_state == S_XFER));

`ifdef EBUS_PARITY_EN
  assign w_par_bad     = ~(^{ebusData, ebusParityIn});
  assign ebusParityOut = w_driving && ~(^r_wdata);
`else
  assign w_par_bad     = 1'b0 & ebusParityIn;
  assign ebusParityOut = 1'b0;
`endif

  assign reqReady   = (r_state == S_IDLE);
  assign ebusCS     = (r_state != S_IDLE) ? r_cs : 7'd0;
  assign ebusFunc   = (r_state != S_IDLE) ? r_func : 3'd0;
  assign ebusDemand = (r_state == S_DEMAND) || (r_state == S_XFER);
  assign ebusDrv    = w_driving ? {r_wdata, 1'b1} : 37'd0;

  assign rspValid   = r_rsp_valid;
  assign rspTimeout = r_rsp_tmo;
  assign rspData    = r_rsp_data;
  assign rspParErr  = r_rsp_perr;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the capture / abort / done events for this cycle.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_illegal) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        if (r_setup_cnt == SETUP_LAST) w_state_next = S_DEMAND;
      end
      S_DEMAND: begin
        if (ebusAck && ebusXfer) begin
          w_capture    = 1'b1;
          w_state_next = S_RELEASE;
        end else if (ebusAck) begin
          w_state_next = S_XFER;
        end else if (w_tmo_hit) begin
          w_abort      = 1'b1;
          w_state_next = S_RELEASE;
        end
      end
      S_XFER: begin
        if (ebusXfer) begin
          w_capture    = 1'b1;
          w_state_next = S_RELEASE;
        end else if (w_tmo_hit) begin
          w_abort      = 1'b1;
          w_state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ebusXfer) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_abort      = 1'b1;
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, read capture, wait counters and the abort flag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_func      <= 3'd0;
      r_cs        <= 7'd0;
      r_wdata     <= 36'd0;
      r_rdata     <= 36'd0;
      r_perr      <= 1'b0;
      r_abort     <= 1'b0;
      r_setup_cnt <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_func  <= reqFunc;
        r_cs    <= reqCS;
        r_wdata <= reqData;
        r_rdata <= 36'd0;
        r_perr  <= 1'b0;
        r_abort <= 1'b0;
      end
      if (w_capture && w_is_read) begin
        r_rdata <= ebusData;
        r_perr  <= w_par_bad;
      end
      if (w_abort) r_abort <= 1'b1;

      if (r_state == S_SETUP) r_setup_cnt <= r_setup_cnt + 1'b1;
      else                    r_setup_cnt <= '0;

      // One shared wait counter: restarts on every state change.
      if (w_state_next != r_state) r_tmo_cnt <= '0;
      else if ((r_state == S_DEMAND) || (r_state == S_XFER) || (r_state == S_RELEASE))
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // One-cycle response: aborted requests report timeout with zero data.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_rsp_data  <= 36'd0;
      r_rsp_perr  <= 1'b0;
    end else begin
      r_rsp_valid <= w_done || w_illegal_acc;
      r_rsp_tmo   <= w_illegal_acc || (w_done && w_any_abort);
      r_rsp_data  <= (w_done && !w_any_abort) ? r_rdata : 36'd0;
      r_rsp_perr  <= w_done && !w_any_abort && r_perr;
    end
  end

endmodule

// File: tb/tb_ebus_master_seq.sv
// Testbench for ebus_master_seq.
// A behavioural EBUS device answers demand with programmable ack/xfer delays and
// xfer hold-off. Fixed vectors carry hand-derived expectations. Random requests
// are checked against a duration-based reference model.
module tb_ebus_master_seq;

  localparam int S     = 2;
  localparam int T     = 64;
  localparam int NEVER = 1000;
`ifdef EBUS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [2:0]  reqFunc = 3'd0;
  logic [6:0]  reqCS = 7'd0;
  logic [35:0] reqData = 36'd0;
  logic        rspValid;
  logic [35:0] rspData;
  logic        rspTimeout;
  logic        rspParErr;
  logic [6:0]  ebusCS;
  logic [2:0]  ebusFunc;
  logic        ebusDemand;
  logic [36:0] ebusDrv;
  logic        ebusParityOut;
  logic [35:0] ebusData = 36'd0;
  logic        ebusParityIn = 1'b0;
  logic        ebusAck = 1'b0;
  logic        ebusXfer = 1'b0;

  always #5 clk = ~clk;

  ebus_master_seq #(.SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqFunc(reqFunc), .reqCS(reqCS), .reqData(reqData),
    .rspValid(rspValid), .rspData(rspData), .rspTimeout(rspTimeout), .rspParErr(rspParErr),
    .ebusCS(ebusCS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand), .ebusDrv(ebusDrv),
    .ebusParityOut(ebusParityOut), .ebusData(ebusData), .ebusParityIn(ebusParityIn),
    .ebusAck(ebusAck), .ebusXfer(ebusXfer)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Device model: ack dev_a cycles into demand, xfer dev_x cycles after ack,
  // xfer held dev_h cycles after demand drops.
  int dev_a = NEVER;
  int dev_x = 0;
  int dev_h = 0;
  int dev_k = 0;
  int dev_hold_left = 0;

  always @(negedge clk) begin
    if (ebusDemand) begin
      ebusAck       = (dev_k >= dev_a);
      ebusXfer      = (dev_k >= dev_a + dev_x);
      dev_k         = dev_k + 1;
      dev_hold_left = dev_h;
    end else begin
      ebusAck = 1'b0;
      dev_k   = 0;
      if (ebusXfer && dev_hold_left > 0) dev_hold_left = dev_hold_left - 1;
      else ebusXfer = 1'b0;
    end
  end

  // Reference model: each phase's duration comes from when the device answers.
  // Latency is counted from the accept cycle to the response cycle.
  function automatic void model(input logic [2:0] f, input int a, input int x, input int h,
                                input logic [35:0] bus, input bit bad,
                                output int lat, output bit tmo, output logic [35:0] data,
                                output bit perr, output int dem);
    int ld;
    int lr;
    bit abort;
    bit got_xfer;
    bit rd;
    if (f >= 3'd6) begin
      lat = 1; tmo = 1'b1; data = 36'd0; perr = 1'b0; dem = 0;
      return;
    end
    abort = 1'b0;
    got_xfer = 1'b0;
    if (a >= T) begin
      ld = T; abort = 1'b1;
    end else if (x <= T) begin
      ld = a + 1 + x; got_xfer = 1'b1;
    end else begin
      ld = a + 1 + T; abort = 1'b1;
    end
    if (!got_xfer) lr = 1;
    else if (h < T) lr = h + 1;
    else begin
      lr = T; abort = 1'b1;
    end
    rd   = (f == 3'd1) || (f == 3'd3) || (f == 3'd5);
    lat  = S + ld + lr + 1;
    tmo  = abort;
    data = (!abort && rd) ? bus : 36'd0;
    perr = PAR_EN && !abort && rd && bad;
    dem  = ld;
  endfunction

  task automatic run_txn(input string tag, input logic [2:0] func, input logic [6:0] cs,
                         input logic [35:0] wd, input int a, input int x, input int h,
                         input logic [35:0] bus, input bit bad,
                         input int exp_lat, input bit exp_tmo, input logic [35:0] exp_data,
                         input bit exp_perr, input int exp_dem);
    int lat;
    int dem;
    bit bus_ok;
    bit got;
    bit wr;
    logic rt;
    logic rp;
    logic [35:0] rd;
    @(negedge clk);
    dev_a = a; dev_x = x; dev_h = h;
    ebusData = bus;
    ebusParityIn = bad ? (^bus) : ~(^bus);
    check({tag, " ready"}, reqReady, 1);
    reqValid = 1'b1; reqFunc = func; reqCS = cs; reqData = wd;
    @(negedge clk);
    reqValid = 1'b0; reqFunc = 3'd0; reqCS = 7'd0; reqData = 36'd0;
    wr = (func == 3'd0) || (func == 3'd2);
    lat = 0; dem = 0; bus_ok = 1'b1; got = 1'b0;
    rt = 1'b0; rp = 1'b0; rd = 36'd0;
    for (int c = 1; c <= 400 && !got; c++) begin
      if (ebusDemand) begin
        dem++;
        if (ebusCS !== cs || ebusFunc !== func) bus_ok = 1'b0;
        if (wr) begin
          if (ebusDrv !== {wd, 1'b1}) bus_ok = 1'b0;
          if (ebusParityOut !== (PAR_EN ? ~(^wd) : 1'b0)) bus_ok = 1'b0;
        end else if (ebusDrv !== 37'd0) bus_ok = 1'b0;
      end
      if (rspValid) begin
        got = 1'b1; lat = c; rt = rspTimeout; rd = rspData; rp = rspParErr;
        check({tag, " idle bus"}, {ebusCS, ebusFunc, ebusDemand, ebusDrv[0]}, 0);
      end else begin
        @(negedge clk);
      end
    end
    check({tag, " rsp seen"}, got, 1);
    if (got) begin
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " timeout"}, rt, exp_tmo);
      check({tag, " data"}, rd, exp_data);
      check({tag, " parerr"}, rp, exp_perr);
      check({tag, " demand cycles"}, dem, exp_dem);
      check({tag, " bus drive"}, bus_ok, 1);
      @(negedge clk);
      check({tag, " rsp pulse"}, rspValid, 0);
    end
    $display("txn %s func=%0d cs=%0o lat=%0d tmo=%0b data=%0o perr=%0b dem=%0d",
             tag, func, cs, lat, rt, rd, rp, dem);
  endtask

  typedef struct {
    logic [2:0]  func;
    logic [6:0]  cs;
    logic [35:0] wd;
    int          a;
    int          x;
    int          h;
    logic [35:0] bus;
    bit          bad;
    int          exp_lat;
    bit          exp_tmo;
    logic [35:0] exp_data;
    bit          exp_perr_en;
    int          exp_dem;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{3'b010, 7'o42, 36'o123456701234, 0, 0, 0, 36'd0, 1'b0, 5, 1'b0, 36'd0, 1'b0, 1};
    vecs[1]  = '{3'b011, 7'o10, 36'd0, 0, 3, 0, 36'o777000111222, 1'b0, 8, 1'b0, 36'o777000111222, 1'b0, 4};
    vecs[2]  = '{3'b000, 7'o01, 36'o5, NEVER, 0, 0, 36'd0, 1'b0, 68, 1'b1, 36'd0, 1'b0, 64};
    vecs[3]  = '{3'b111, 7'o11, 36'o7, 0, 0, 0, 36'd0, 1'b0, 1, 1'b1, 36'd0, 1'b0, 0};
    vecs[4]  = '{3'b110, 7'o12, 36'o7, 0, 0, 0, 36'd0, 1'b0, 1, 1'b1, 36'd0, 1'b0, 0};
    vecs[5]  = '{3'b001, 7'o03, 36'd0, 2, 0, 0, 36'o777, 1'b0, 7, 1'b0, 36'o777, 1'b0, 3};
    vecs[6]  = '{3'b100, 7'o04, 36'd0, 0, 0, 0, 36'o55, 1'b0, 5, 1'b0, 36'd0, 1'b0, 1};
    vecs[7]  = '{3'b101, 7'o05, 36'd0, 1, 1, 0, 36'o17, 1'b0, 7, 1'b0, 36'o17, 1'b0, 3};
    vecs[8]  = '{3'b011, 7'o06, 36'd0, 63, 0, 0, 36'o1, 1'b0, 68, 1'b0, 36'o1, 1'b0, 64};
    vecs[9]  = '{3'b011, 7'o07, 36'd0, 0, 64, 0, 36'o2, 1'b0, 69, 1'b0, 36'o2, 1'b0, 65};
    vecs[10] = '{3'b011, 7'o07, 36'd0, 0, 65, 0, 36'o3, 1'b0, 69, 1'b1, 36'd0, 1'b0, 65};
    vecs[11] = '{3'b011, 7'o20, 36'd0, 0, 0, 63, 36'o4, 1'b0, 68, 1'b0, 36'o4, 1'b0, 1};
    vecs[12] = '{3'b011, 7'o21, 36'd0, 0, 0, 64, 36'o4, 1'b0, 68, 1'b1, 36'd0, 1'b0, 1};
    vecs[13] = '{3'b001, 7'o22, 36'd0, 0, 0, 0, 36'o6, 1'b1, 5, 1'b0, 36'o6, 1'b1, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset reqReady", reqReady, 1);
    check("reset outputs", {rspValid, rspTimeout, rspParErr, ebusDemand, ebusParityOut}, 0);
    check("reset bus", {ebusCS, ebusFunc, ebusDrv, rspData}, 0);
    resetN = 1'b1;

    // Fixed vectors.
    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].func, vecs[i].cs, vecs[i].wd,
              vecs[i].a, vecs[i].x, vecs[i].h, vecs[i].bus, vecs[i].bad,
              vecs[i].exp_lat, vecs[i].exp_tmo, vecs[i].exp_data,
              PAR_EN && vecs[i].exp_perr_en, vecs[i].exp_dem);
    end

    // Asynchronous reset while a write sits in XFER.
    begin
      bit saw_rsp;
      @(negedge clk);
      dev_a = 0; dev_x = 10; dev_h = 0;
      reqValid = 1'b1; reqFunc = 3'b010; reqCS = 7'o5; reqData = 36'o1234;
      @(negedge clk);
      reqValid = 1'b0;
      repeat (4) @(negedge clk);
      check("rst pre demand", ebusDemand, 1);
      check("rst pre driving", ebusDrv[0], 1);
      #2 resetN = 1'b0;
      #1;
      check("rst async demand", ebusDemand, 0);
      check("rst async drv", ebusDrv, 0);
      check("rst async ready", reqReady, 1);
      saw_rsp = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (rspValid) saw_rsp = 1'b1;
      end
      resetN = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (rspValid) saw_rsp = 1'b1;
      end
      check("rst no rsp", saw_rsp, 0);
      $display("txn reset-during-xfer saw_rsp=%0b", saw_rsp);
      run_txn("post-reset", vecs[0].func, vecs[0].cs, vecs[0].wd, 0, 0, 0, 36'd0, 1'b0,
              5, 1'b0, 36'd0, 1'b0, 1);
    end

    // Randomised requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [6:0]  cs;
      logic [63:0] r64;
      logic [35:0] wd;
      logic [35:0] bus;
      int a, x, h, r;
      bit bad;
      int e_lat, e_dem;
      bit e_tmo, e_perr;
      logic [35:0] e_data;
      f = 3'($urandom_range(0, 7));
      cs = 7'($urandom_range(0, 127));
      r64 = {$urandom, $urandom}; wd = r64[35:0];
      r64 = {$urandom, $urandom}; bus = r64[35:0];
      bad = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      a = (r < 5) ? r : (r < 8) ? int'($urandom_range(5, 20)) : (r == 8) ? 63 : NEVER;
      r = $urandom_range(0, 9);
      x = (r < 4) ? 0 : (r < 8) ? int'($urandom_range(1, 6)) : (r == 8) ? 64 : 70;
      r = $urandom_range(0, 9);
      h = (r < 6) ? 0 : (r < 9) ? int'($urandom_range(1, 5)) : 64;
      model(f, a, x, h, bus, bad, e_lat, e_tmo, e_data, e_perr, e_dem);
      run_txn($sformatf("rnd%0d", i), f, cs, wd, a, x, h, bus, bad,
              e_lat, e_tmo, e_data, e_perr, e_dem);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
